// File: rtl/cpu_pkg.sv
// Shared CPU datapath defaults and the register index type.
package cpu_pkg;
    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned DEPTH_DEF  = 4;
    localparam int unsigned ADDR_W_DEF = $clog2(DEPTH_DEF);

    typedef logic [ADDR_W_DEF-1:0] reg_idx_t;
endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending bits marking outstanding long-latency producers.
module reg_scoreboard
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH    = DEPTH_DEF,
    parameter int unsigned ADDR_W   = $clog2(DEPTH),
    parameter int unsigned ZERO_REG = 0,
    parameter int unsigned BYPASS   = 1
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              PendSet,
    input  logic [ADDR_W-1:0] PendRD,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] RD,
    input  logic [ADDR_W-1:0] RS,
    input  logic [ADDR_W-1:0] RT,
    output logic              BusyRS,
    output logic              BusyRT,
    output logic              PendAny
);
    logic [DEPTH-1:0] pend_q;
    logic [DEPTH-1:0] pend_d;
    logic             set_en;

    assign set_en = PendSet && !((ZERO_REG != 0) && (PendRD == '0));

    // Set is applied after clear so a new producer issued as the old one retires wins.
    always_comb begin
        pend_d = pend_q;
        if (RegWrite) begin
            pend_d[RD] = 1'b0;
        end
        if (set_en) begin
            pend_d[PendRD] = 1'b1;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    always_comb begin
        BusyRS  = pend_q[RS] && !((BYPASS != 0) && RegWrite && (RD == RS));
        BusyRT  = pend_q[RT] && !((BYPASS != 0) && RegWrite && (RD == RT));
        PendAny = |pend_q;
    end
endmodule

// File: rtl/reg_file_sb.sv
// Parametrised two-read, one-write register file with write bypass and a
// load-use scoreboard.
module reg_file_sb
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned DEPTH    = DEPTH_DEF,
    parameter int unsigned ADDR_W   = $clog2(DEPTH),
    parameter int unsigned ZERO_REG = 0,
    parameter int unsigned BYPASS   = 1
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] RS,
    input  logic [ADDR_W-1:0] RT,
    input  logic [ADDR_W-1:0] RD,
    input  logic [DATA_W-1:0] WD,
    input  logic              RegWrite,
    output logic [DATA_W-1:0] ReadRS,
    output logic [DATA_W-1:0] ReadRT,
    input  logic              PendSet,
    input  logic [ADDR_W-1:0] PendRD,
    output logic              BusyRS,
    output logic              BusyRT,
    output logic              PendAny
);
    logic [DATA_W-1:0] regs_q [DEPTH];
    logic              wr_en;
    logic              fwd_rs;
    logic              fwd_rt;

    assign wr_en = RegWrite && !((ZERO_REG != 0) && (RD == '0));

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[RD] <= WD;
        end
    end

    assign fwd_rs = (BYPASS != 0) && wr_en && (RD == RS);
    assign fwd_rt = (BYPASS != 0) && wr_en && (RD == RT);

    // Reset forces zero so a write presented during reset is not forwarded.
    always_comb begin
        ReadRS = '0;
        ReadRT = '0;
        if (!Reset) begin
            ReadRS = fwd_rs ? WD : regs_q[RS];
            ReadRT = fwd_rt ? WD : regs_q[RT];
            if ((ZERO_REG != 0) && (RS == '0)) ReadRS = '0;
            if ((ZERO_REG != 0) && (RT == '0)) ReadRT = '0;
        end
    end

    reg_scoreboard #(
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_scoreboard (
        .Clock    (Clock),
        .Reset    (Reset),
        .PendSet  (PendSet),
        .PendRD   (PendRD),
        .RegWrite (RegWrite),
        .RD       (RD),
        .RS       (RS),
        .RT       (RT),
        .BusyRS   (BusyRS),
        .BusyRT   (BusyRT),
        .PendAny  (PendAny)
    );
endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: default, no-bypass and zero-register builds.
module tb_reg_file_sb;
    import cpu_pkg::*;

    typedef struct {
        reg_idx_t    rs;
        reg_idx_t    rt;
        reg_idx_t    rd;
        logic [15:0] wd;
        logic        we;
        logic        ps;
        reg_idx_t    prd;
        logic [15:0] ers;
        logic [15:0] ert;
        logic        ebs;
        logic        ebt;
        logic        epa;
    } vec_t;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    reg_idx_t    RS = '0, RT = '0, RD = '0, PendRD = '0;
    logic [15:0] WD = '0;
    logic        RegWrite = 1'b0, PendSet = 1'b0;

    logic [15:0] a_rs, a_rt, n_rs, n_rt, z_rs, z_rt;
    logic        a_bs, a_bt, a_pa, n_bs, n_bt, n_pa, z_bs, z_bt, z_pa;

    int passed = 0;
    int total  = 0;
    vec_t vecs [13];

    always #5 Clock = ~Clock;

    reg_file_sb #(.BYPASS(1), .ZERO_REG(0)) dut (
        .Clock(Clock), .Reset(Reset), .RS(RS), .RT(RT), .RD(RD), .WD(WD),
        .RegWrite(RegWrite), .ReadRS(a_rs), .ReadRT(a_rt), .PendSet(PendSet),
        .PendRD(PendRD), .BusyRS(a_bs), .BusyRT(a_bt), .PendAny(a_pa)
    );

    reg_file_sb #(.BYPASS(0), .ZERO_REG(0)) dut_nb (
        .Clock(Clock), .Reset(Reset), .RS(RS), .RT(RT), .RD(RD), .WD(WD),
        .RegWrite(RegWrite), .ReadRS(n_rs), .ReadRT(n_rt), .PendSet(PendSet),
        .PendRD(PendRD), .BusyRS(n_bs), .BusyRT(n_bt), .PendAny(n_pa)
    );

    reg_file_sb #(.BYPASS(1), .ZERO_REG(1)) dut_z (
        .Clock(Clock), .Reset(Reset), .RS(RS), .RT(RT), .RD(RD), .WD(WD),
        .RegWrite(RegWrite), .ReadRS(z_rs), .ReadRT(z_rt), .PendSet(PendSet),
        .PendRD(PendRD), .BusyRS(z_bs), .BusyRT(z_bt), .PendAny(z_pa)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
    endtask

    task automatic drive(input reg_idx_t rs, input reg_idx_t rt, input reg_idx_t rd,
                         input logic [15:0] wd, input logic we, input logic ps,
                         input reg_idx_t prd);
        RS = rs; RT = rt; RD = rd; WD = wd; RegWrite = we; PendSet = ps; PendRD = prd;
    endtask

    task automatic idle();
        drive(2'd0, 2'd0, 2'd0, 16'h0000, 1'b0, 1'b0, 2'd0);
    endtask

    task automatic next_cycle();
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset();
        idle();
        Reset = 1'b1;
        next_cycle();
        next_cycle();
        Reset = 1'b0;
    endtask

    initial begin
        // rs rt rd wd we ps prd | ReadRS ReadRT BusyRS BusyRT PendAny (BYPASS=1, ZERO_REG=0)
        vecs[0]  = '{2'd0, 2'd1, 2'd0, 16'h0000, 1'b0, 1'b0, 2'd0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{2'd2, 2'd3, 2'd2, 16'hBEEF, 1'b1, 1'b0, 2'd0, 16'hBEEF, 16'h0000, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{2'd2, 2'd3, 2'd3, 16'h1234, 1'b1, 1'b0, 2'd0, 16'hBEEF, 16'h1234, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{2'd2, 2'd3, 2'd0, 16'h0000, 1'b0, 1'b0, 2'd0, 16'hBEEF, 16'h1234, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{2'd1, 2'd2, 2'd1, 16'hA5A5, 1'b1, 1'b0, 2'd0, 16'hA5A5, 16'hBEEF, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{2'd1, 2'd3, 2'd0, 16'h0000, 1'b0, 1'b1, 2'd3, 16'hA5A5, 16'h1234, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{2'd3, 2'd3, 2'd0, 16'h0000, 1'b0, 1'b0, 2'd0, 16'h1234, 16'h1234, 1'b1, 1'b1, 1'b1};
        vecs[7]  = '{2'd0, 2'd3, 2'd3, 16'h5555, 1'b1, 1'b1, 2'd3, 16'h0000, 16'h5555, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{2'd3, 2'd3, 2'd0, 16'h0000, 1'b0, 1'b0, 2'd0, 16'h5555, 16'h5555, 1'b1, 1'b1, 1'b1};
        vecs[9]  = '{2'd1, 2'd3, 2'd3, 16'h6666, 1'b1, 1'b0, 2'd0, 16'hA5A5, 16'h6666, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{2'd3, 2'd2, 2'd0, 16'h0000, 1'b0, 1'b0, 2'd0, 16'h6666, 16'hBEEF, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{2'd1, 2'd2, 2'd2, 16'h7777, 1'b1, 1'b1, 2'd1, 16'hA5A5, 16'h7777, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{2'd1, 2'd2, 2'd0, 16'h0000, 1'b0, 1'b0, 2'd0, 16'hA5A5, 16'h7777, 1'b1, 1'b0, 1'b1};

        // Reset, then every index reads zero and nothing is busy.
        #1;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(reg_idx_t'(i), reg_idx_t'(3 - i), 2'd0, 16'h0000, 1'b0, 1'b0, 2'd0);
            #2;
            chk($sformatf("rst_rs[%0d]", i), a_rs, 16'h0000);
            chk($sformatf("rst_rt[%0d]", i), a_rt, 16'h0000);
            chk($sformatf("rst_busy[%0d]", i), 16'({a_bs, a_bt, a_pa}), 16'h0000);
        end
        next_cycle();

        // Main table against the default build.
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].wd, vecs[i].we, vecs[i].ps,
                  vecs[i].prd);
            #2;
            chk($sformatf("v%0d_ReadRS", i), a_rs, vecs[i].ers);
            chk($sformatf("v%0d_ReadRT", i), a_rt, vecs[i].ert);
            chk($sformatf("v%0d_BusyRS", i), 16'(a_bs), 16'(vecs[i].ebs));
            chk($sformatf("v%0d_BusyRT", i), 16'(a_bt), 16'(vecs[i].ebt));
            chk($sformatf("v%0d_PendAny", i), 16'(a_pa), 16'(vecs[i].epa));
            next_cycle();
        end

        // Bypass vs. no bypass on the same write cycle.
        do_reset();
        drive(2'd1, 2'd1, 2'd1, 16'hA5A5, 1'b1, 1'b0, 2'd0);
        #2;
        chk("byp_on_rs", a_rs, 16'hA5A5);
        chk("byp_off_rs", n_rs, 16'h0000);
        chk("byp_off_rt", n_rt, 16'h0000);
        next_cycle();
        idle();
        RS = 2'd1;
        #2;
        chk("byp_off_after", n_rs, 16'hA5A5);

        // Zero register: write and PendSet to r0 are dropped.
        drive(2'd0, 2'd0, 2'd0, 16'hFFFF, 1'b1, 1'b1, 2'd0);
        #2;
        chk("zero_rs_wcyc", z_rs, 16'h0000);
        chk("zero_busy_wcyc", 16'(z_bs), 16'h0000);
        chk("nozero_rs_wcyc", a_rs, 16'hFFFF);
        next_cycle();
        idle();
        #2;
        chk("zero_rs_next", z_rs, 16'h0000);
        chk("zero_rt_next", z_rt, 16'h0000);
        chk("zero_busy_next", 16'({z_bs, z_pa}), 16'h0000);
        chk("nozero_rs_next", a_rs, 16'hFFFF);
        chk("nozero_busy_next", 16'({a_bs, a_pa}), 16'h0003);
        next_cycle();

        // Asynchronous reset between edges clears state immediately.
        do_reset();
        drive(2'd1, 2'd2, 2'd1, 16'h00FF, 1'b1, 1'b1, 2'd2);
        next_cycle();
        idle();
        RS = 2'd1;
        RT = 2'd2;
        #1;
        chk("mid_pre_rs", a_rs, 16'h00FF);
        chk("mid_pre_bt", 16'(a_bt), 16'h0001);
        Reset = 1'b1;
        #1;
        chk("mid_rs", a_rs, 16'h0000);
        chk("mid_bt", 16'(a_bt), 16'h0000);
        chk("mid_pa", 16'(a_pa), 16'h0000);
        RS = 2'd2;
        #1;
        chk("mid_bs", 16'(a_bs), 16'h0000);
        next_cycle();
        Reset = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised successor to the 4x16 CPU register file.
- Configurable data width and register count.
- Adds asynchronous reset, an optional hardwired-zero register 0, and write-to-read bypass.
- Adds a per-register pending scoreboard so the decode stage can detect load-use hazards.
- Sits between decode (RS/RT/RD indices) and writeback (WD/RegWrite) in the 16-bit CPU datapath.

Parameters:
- DATA_W, 16: register width in bits.
- DEPTH, 4: number of registers. Power of two, 2..64.
- ADDR_W, $clog2(DEPTH): index width. Derived; not to be overridden.
- ZERO_REG, 0: 1 = register 0 always reads 0; writes and pending-sets to it are ignored.
- BYPASS, 1: 1 = same-cycle write data is forwarded to the read ports.

Ports:
- Clock  input  1  single clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- RS  input  ADDR_W  read port A index.
- RT  input  ADDR_W  read port B index.
- RD  input  ADDR_W  write index.
- WD  input  DATA_W  write data.
- RegWrite  input  1  write enable.
- ReadRS  output  DATA_W  port A read data (combinational).
- ReadRT  output  DATA_W  port B read data (combinational).
- PendSet  input  1  mark register PendRD as pending (long-latency producer issued).
- PendRD  input  ADDR_W  index to mark pending.
- BusyRS  output  1  register RS has an outstanding producer.
- BusyRT  output  1  register RT has an outstanding producer.
- PendAny  output  1  OR of all pending bits (registered state, combinational OR).

Behaviour:
- Reset asserted (any time, asynchronous):
  - all registers become 0 and all pending bits become 0;
  - ReadRS/ReadRT read 0; BusyRS, BusyRT and PendAny are 0.
  - Reset mid-operation discards any write or PendSet in that cycle.
- Write: at posedge, if RegWrite and not Reset, Registers[RD] <= WD. Visible through the array on the next cycle.
- Zero register (ZERO_REG=1, RD==0):
  - the write is dropped and index 0 reads 0 on both ports regardless of bypass;
  - a PendSet with PendRD==0 is dropped.
- Read, combinational, zero latency:
  - if BYPASS=1, RegWrite=1 and RD==RS (RD!=0 when ZERO_REG=1), then ReadRS = WD;
  - otherwise ReadRS = Registers[RS];
  - ReadRT follows the identical rule;
  - RS==RT is legal and both ports return the same value.
- With BYPASS=0: a read of RD in the write cycle returns the old value.
- Scoreboard, one pending bit per register, updated at posedge:
  - RegWrite clears pending[RD];
  - PendSet sets pending[PendRD];
  - same index in the same cycle: set wins and the bit stays 1 (a new producer is issued as the old one retires);
  - different indices: both take effect.
  - Setting an already-pending bit leaves it at 1 (no counting).
  - A write to a non-pending register is legal and does not affect the scoreboard.
- Busy outputs:
  - BusyRS = pending[RS], except when BYPASS=1 and this cycle's RegWrite targets RS, in which case BusyRS = 0;
  - BusyRT follows the same rule;
  - index 0 is never busy when ZERO_REG=1.
- Widths: no arithmetic. All indices are full-range, so there are no out-of-range cases.
- No X may propagate to outputs after reset.

Decomposition:
- Shared package cpu_pkg holds:
  - DATA_W default (16) and DEPTH default (4);
  - a reg_idx_t typedef sized by ADDR_W.
- One natural sub-module: reg_scoreboard
  - contents: the pending-bit vector, set/clear priority, and Busy/PendAny generation;
  - ports: Clock, Reset, PendSet, PendRD, RegWrite, RD, RS, RT.
- The data array and bypass muxes stay in reg_file_sb.

Test Plan:
- Reset then read: assert Reset for 2 cycles, read all indices on RS/RT -> every ReadRS/ReadRT = 0x0000, BusyRS/BusyRT/PendAny = 0.
- Write/read: write 0xBEEF to r2, then 0x1234 to r3; next cycle RS=2, RT=3 -> ReadRS=0xBEEF, ReadRT=0x1234.
- Bypass: with BYPASS=1, RegWrite=1, RD=1, WD=0xA5A5, RS=1 in the same cycle -> ReadRS=0xA5A5 that cycle. With BYPASS=0 the same stimulus -> old value (0x0000 after reset).
- Zero register: with ZERO_REG=1, write 0xFFFF to r0 and PendSet r0 -> ReadRS(RS=0)=0x0000 and BusyRS=0 in that cycle and the next.
- Scoreboard:
  - PendSet r3 -> BusyRT(RT=3)=1 and PendAny=1 from the next cycle;
  - then RegWrite RD=3 together with PendSet PendRD=3 -> bit stays 1;
  - then RegWrite RD=3 alone -> BusyRT=0 in that cycle (bypass) and PendAny=0 after the edge.
- Reset mid-operation: write 0x00FF to r1 and PendSet r2, then assert Reset asynchronously between edges -> ReadRS(RS=1)=0 and BusyRS(RS=2)=0 immediately, before the next Clock edge.
